// File: rtl/board_io_pkg.sv
// Shared board I/O constants and width helpers, reused by the CPU top,
// the display driver and the input conditioner.
package board_io_pkg;

   localparam int N_CH_DEF         = 12;
   localparam int DEBOUNCE_CYC_DEF = 16;
   localparam int SYNC_STAGES_DEF  = 2;

   // Width of a channel index; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int debounce_cyc);
      return $clog2(debounce_cyc + 1);
   endfunction

endpackage

// File: rtl/board_input_cond_if.sv
// Switch bus and change-event handshake between the input conditioner and its consumer.
interface board_input_cond_if
   import board_io_pkg::*;
#(
   parameter int N_CH = N_CH_DEF
);
   localparam int IW = idx_w(N_CH);

   logic [N_CH-1:0] sw_raw;
   logic [N_CH-1:0] sw_stable;
   logic [N_CH-1:0] sw_rise;
   logic [N_CH-1:0] sw_fall;
   logic            chg_valid;
   logic            chg_ready;
   logic [IW-1:0]   chg_idx;
   logic            chg_dir;

   modport master (
      input  sw_raw, chg_ready,
      output sw_stable, sw_rise, sw_fall, chg_valid, chg_idx, chg_dir
   );

   modport slave (
      output sw_raw, chg_ready,
      input  sw_stable, sw_rise, sw_fall, chg_valid, chg_idx, chg_dir
   );

endinterface

// File: rtl/input_debounce_ch.sv
// One input channel: synchroniser chain, debounce counter, stable flop and edge pulses.
module input_debounce_ch
   import board_io_pkg::*;
#(
   parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter bit RST_VAL      = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall,
   output logic upd
);
   localparam int             CW   = cnt_w(DEBOUNCE_CYC);
   localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYC - 1);

   logic [SYNC_STAGES-1:0] sync_p;
   logic                   sync;
   logic [CW-1:0]          cnt;

   assign sync = sync_p[SYNC_STAGES-1];
   // stable takes the synchronised level on the next edge
   assign upd  = (sync != stable) && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p <= {SYNC_STAGES{RST_VAL}};
         stable <= RST_VAL;
         cnt    <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
         rise   <= upd & sync;
         fall   <= upd & ~sync;
         if (sync == stable) begin
            cnt <= '0;
         end else if (upd) begin
            stable <= sync;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/board_input_cond.sv
// N-channel switch conditioner; the change-event queue is built only when
// BOARD_INPUT_COND_EVENT_QUEUE_EN is defined.
module board_input_cond
   import board_io_pkg::*;
#(
   parameter int              N_CH         = N_CH_DEF,
   parameter int              DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter int              SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter logic [N_CH-1:0] RST_VAL      = '0
) (
   input logic clk,
   input logic rst_n,
   board_input_cond_if.master bus
);
   localparam int IW = idx_w(N_CH);

   logic [N_CH-1:0] stable;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
   logic [N_CH-1:0] upd;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      input_debounce_ch #(
         .SYNC_STAGES  (SYNC_STAGES),
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .RST_VAL      (RST_VAL[i])
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .raw    (bus.sw_raw[i]),
         .stable (stable[i]),
         .rise   (rise[i]),
         .fall   (fall[i]),
         .upd    (upd[i])
      );
   end

   assign bus.sw_stable = stable;
   assign bus.sw_rise   = rise;
   assign bus.sw_fall   = fall;

`ifdef BOARD_INPUT_COND_EVENT_QUEUE_EN
   logic [N_CH-1:0] pend;
   logic [N_CH-1:0] clr;
   logic [IW-1:0]   idx;
   logic            accept;

   // Lowest pending index wins: later (lower) iterations overwrite.
   always_comb begin
      idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (pend[i]) idx = IW'(i);
      end
   end

   assign accept = (|pend) && bus.chg_ready;

   always_comb begin
      clr = '0;
      if (accept) clr[idx] = 1'b1;
   end

   // A new change outranks a same-cycle acceptance, so it is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend <= '0;
      else        pend <= (pend & ~clr) | upd;
   end

   assign bus.chg_valid = |pend;
   assign bus.chg_idx   = idx;
   assign bus.chg_dir   = stable[idx];
`else
   logic unused_in;
   assign unused_in     = &{1'b0, upd, bus.chg_ready};

   assign bus.chg_valid = 1'b0;
   assign bus.chg_idx   = '0;
   assign bus.chg_dir   = 1'b0;
`endif

endmodule
